// File: rtl/simple_reg_pkg.sv
// Shared types and helpers for the serial register read-back path.
package simple_reg_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StShift = 2'd2
  } state_e;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/simple_reg_reader_if.sv
// Request, bank read port and serial output bundle of the register reader.
interface simple_reg_reader_if #(
  parameter int unsigned DATA_W = simple_reg_pkg::DefDataW,
  parameter int unsigned ADDR_W = simple_reg_pkg::DefAddrW
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_busy;
  logic              rd_drop;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_rdata;
  logic              dout;
  logic              dout_valid;
  logic              dout_last;
  logic              dout_ready;

  modport master (
    output rd_req, rd_addr, bank_rdata, dout_ready,
    input  rd_busy, rd_drop, bank_addr, dout, dout_valid, dout_last
  );

  modport slave (
    input  rd_req, rd_addr, bank_rdata, dout_ready,
    output rd_busy, rd_drop, bank_addr, dout, dout_valid, dout_last
  );

endinterface

// File: rtl/simple_reg_piso.sv
// Parallel-load shift register with a down-counter flagging the final bit.
module simple_reg_piso
  import simple_reg_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              i_load,
  input  logic              i_shift_en,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bit,
  output logic              o_last
);

  localparam int unsigned CntW = clog2(DATA_W);

  logic [DATA_W-1:0] r_shreg;
  logic [CntW-1:0]   r_cnt;

  // The final bit is never shifted away, so the count cannot wrap below zero.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
      r_cnt   <= CntW'(DATA_W - 1);
    end else if (i_shift_en && (r_cnt != '0)) begin
      if (MSB_FIRST) begin
        r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
      end else begin
        r_shreg <= {1'b0, r_shreg[DATA_W-1:1]};
      end
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign o_bit  = MSB_FIRST ? r_shreg[DATA_W-1] : r_shreg[0];
  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/simple_reg_reader.sv
// Fetches one bank register on request and streams it out serially with
// a valid/ready handshake.
module simple_reg_reader
  import simple_reg_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               reset_l,
  simple_reg_reader_if.slave bus
);

  state_e            r_state;
  logic              r_busy;
  logic              r_drop;
  logic              r_valid;
  logic [ADDR_W-1:0] r_bank_addr;

  logic w_load;
  logic w_shift_en;
  logic w_bit;
  logic w_last;

  assign w_load     = (r_state == StFetch);
  assign w_shift_en = r_valid & bus.dout_ready;

  simple_reg_piso #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk        (clk),
    .reset_l    (reset_l),
    .i_load     (w_load),
    .i_shift_en (w_shift_en),
    .i_data     (bus.bank_rdata),
    .o_bit      (w_bit),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_drop      <= 1'b0;
      r_valid     <= 1'b0;
      r_bank_addr <= '0;
    end else begin
      r_drop <= bus.rd_req && (r_state != StIdle);
      case (r_state)
        StIdle: begin
          if (bus.rd_req) begin
            r_bank_addr <= bus.rd_addr;
            r_busy      <= 1'b1;
            r_state     <= StFetch;
          end
        end
        StFetch: begin
          r_valid <= 1'b1;
          r_state <= StShift;
        end
        StShift: begin
          if (bus.dout_ready && w_last) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Gating keeps dout low outside a word; both terms are registers.
  assign bus.dout       = r_valid & w_bit;
  assign bus.dout_last  = r_valid & w_last;
  assign bus.dout_valid = r_valid;
  assign bus.rd_busy    = r_busy;
  assign bus.rd_drop    = r_drop;
  assign bus.bank_addr  = r_bank_addr;

endmodule

// File: tb/tb_simple_reg_reader.sv
// Scoreboard bench: expected beats are queued at request time and popped by
// per-DUT monitors on every accepted output beat.
module tb_simple_reg_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  typedef struct packed {
    logic b;
    logic last;
  } beat_t;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] bank [16];

  simple_reg_reader_if #(.DATA_W(DW), .ADDR_W(AW)) u_if_m ();
  simple_reg_reader_if #(.DATA_W(DW), .ADDR_W(AW)) u_if_l ();

  assign u_if_m.bank_rdata = bank[u_if_m.bank_addr];
  assign u_if_l.bank_rdata = bank[u_if_l.bank_addr];

  simple_reg_reader #(.DATA_W(DW), .ADDR_W(AW), .MSB_FIRST(1'b1)) u_dut_m (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (u_if_m.slave)
  );

  simple_reg_reader #(.DATA_W(DW), .ADDR_W(AW), .MSB_FIRST(1'b0)) u_dut_l (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (u_if_l.slave)
  );

  int checks = 0;
  int errors = 0;

  beat_t q_m[$];
  beat_t q_l[$];
  int acc_m = 0;
  int acc_l = 0;
  logic [DW-1:0] rx_m = '0;
  logic [DW-1:0] rx_l = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void push_m(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) q_m.push_back('{b: w[i], last: (i == 0)});
  endfunction

  function automatic void push_l(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) q_l.push_back('{b: w[i], last: (i == DW - 1)});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MSB-first monitor
  logic  hold_m = 1'b0;
  beat_t prev_m;
  always @(negedge clk) begin
    beat_t exp_b;
    if (!reset_l) begin
      hold_m = 1'b0;
    end else if (!u_if_m.dout_valid) begin
      check("m_dout_idle", {31'd0, u_if_m.dout}, 32'd0);
      hold_m = 1'b0;
    end else begin
      if (hold_m) begin
        check("m_hold_dout", {31'd0, u_if_m.dout}, {31'd0, prev_m.b});
        check("m_hold_last", {31'd0, u_if_m.dout_last}, {31'd0, prev_m.last});
      end
      prev_m = '{b: u_if_m.dout, last: u_if_m.dout_last};
      hold_m = !u_if_m.dout_ready;
      if (u_if_m.dout_ready) begin
        acc_m++;
        rx_m = {rx_m[DW-2:0], u_if_m.dout};
        if (q_m.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_unexpected_beat actual=%0b required=none", u_if_m.dout);
        end else begin
          exp_b = q_m.pop_front();
          check("m_dout", {31'd0, u_if_m.dout}, {31'd0, exp_b.b});
          check("m_last", {31'd0, u_if_m.dout_last}, {31'd0, exp_b.last});
        end
      end
    end
  end

  // LSB-first monitor
  always @(negedge clk) begin
    beat_t exp_b;
    if (reset_l && u_if_l.dout_valid && u_if_l.dout_ready) begin
      acc_l++;
      rx_l = {u_if_l.dout, rx_l[DW-1:1]};
      if (q_l.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL l_unexpected_beat actual=%0b required=none", u_if_l.dout);
      end else begin
        exp_b = q_l.pop_front();
        check("l_dout", {31'd0, u_if_l.dout}, {31'd0, exp_b.b});
        check("l_last", {31'd0, u_if_l.dout_last}, {31'd0, exp_b.last});
      end
    end else if (reset_l && !u_if_l.dout_valid) begin
      check("l_dout_idle", {31'd0, u_if_l.dout}, 32'd0);
    end
  end

  task automatic wait_idle_m(output int n);
    n = 0;
    while (u_if_m.rd_busy && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL m_busy_timeout actual=%0d required=<100", n);
    end
  endtask

  task automatic start_m(input logic [AW-1:0] addr);
    acc_m = 0;
    rx_m  = '0;
    u_if_m.rd_req  = 1'b1;
    u_if_m.rd_addr = addr;
    push_m(bank[addr]);
    tick();
    u_if_m.rd_req = 1'b0;
  endtask

  initial begin
    automatic logic [3:0] rdy_pat = 4'b1001;
    int n;
    for (int i = 0; i < 16; i++) bank[i] = '0;
    bank[1] = 8'h01;
    bank[2] = 8'hFF;
    bank[3] = 8'hA5;
    bank[5] = 8'h3C;
    bank[7] = 8'h5A;
    u_if_m.rd_req = 1'b0;
    u_if_m.rd_addr = '0;
    u_if_m.dout_ready = 1'b1;
    u_if_l.rd_req = 1'b0;
    u_if_l.rd_addr = '0;
    u_if_l.dout_ready = 1'b1;

    // Reset then idle
    #8;
    check("rst_busy", {31'd0, u_if_m.rd_busy}, 32'd0);
    check("rst_valid", {31'd0, u_if_m.dout_valid}, 32'd0);
    check("rst_last", {31'd0, u_if_m.dout_last}, 32'd0);
    check("rst_drop", {31'd0, u_if_m.rd_drop}, 32'd0);
    check("rst_bank_addr", {28'd0, u_if_m.bank_addr}, 32'd0);
    #3 reset_l = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_busy", {31'd0, u_if_m.rd_busy}, 32'd0);
      check("idle_valid", {31'd0, u_if_m.dout_valid}, 32'd0);
      check("idle_drop", {31'd0, u_if_m.rd_drop}, 32'd0);
    end
    check("idle_bank_addr", {28'd0, u_if_m.bank_addr}, 32'd0);

    // Single read, ready high
    start_m(4'd3);
    check("rd_busy_after_req", {31'd0, u_if_m.rd_busy}, 32'd1);
    check("rd_bank_addr", {28'd0, u_if_m.bank_addr}, 32'd3);
    check("rd_no_valid_in_fetch", {31'd0, u_if_m.dout_valid}, 32'd0);
    wait_idle_m(n);
    check("rd_busy_cycles", n, DW + 1);
    check("rd_beats", acc_m, DW);
    check("rd_word", {24'd0, rx_m}, 32'hA5);
    check("rd_queue_empty", q_m.size(), 0);
    tick();
    check("rd_bank_addr_held", {28'd0, u_if_m.bank_addr}, 32'd3);

    // Backpressure
    start_m(4'd5);
    n = 0;
    while (u_if_m.rd_busy && n < 100) begin
      u_if_m.dout_ready = rdy_pat[3 - (n % 4)];
      tick();
      n++;
    end
    u_if_m.dout_ready = 1'b1;
    check("bp_no_timeout", {31'd0, u_if_m.rd_busy}, 32'd0);
    check("bp_beats", acc_m, DW);
    check("bp_word", {24'd0, rx_m}, 32'h3C);
    check("bp_queue_empty", q_m.size(), 0);
    tick();

    // Request while busy
    start_m(4'd3);
    tick();
    u_if_m.rd_req  = 1'b1;
    u_if_m.rd_addr = 4'd7;
    tick();
    check("drop_1", {31'd0, u_if_m.rd_drop}, 32'd1);
    tick();
    check("drop_2", {31'd0, u_if_m.rd_drop}, 32'd1);
    u_if_m.rd_req = 1'b0;
    tick();
    check("drop_end", {31'd0, u_if_m.rd_drop}, 32'd0);
    check("drop_bank_addr", {28'd0, u_if_m.bank_addr}, 32'd3);
    wait_idle_m(n);
    check("drop_beats", acc_m, DW);
    check("drop_word", {24'd0, rx_m}, 32'hA5);
    check("drop_bank_addr_end", {28'd0, u_if_m.bank_addr}, 32'd3);
    tick();

    // Reset mid-operation
    start_m(4'd2);
    n = 0;
    while (acc_m < 3 && n < 50) begin
      tick();
      n++;
    end
    check("mid_beats_before_rst", acc_m, 3);
    reset_l = 1'b0;
    #1;
    check("mid_valid", {31'd0, u_if_m.dout_valid}, 32'd0);
    check("mid_busy", {31'd0, u_if_m.rd_busy}, 32'd0);
    check("mid_dout", {31'd0, u_if_m.dout}, 32'd0);
    q_m.delete();
    #1 reset_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_valid", {31'd0, u_if_m.dout_valid}, 32'd0);
      check("post_rst_busy", {31'd0, u_if_m.rd_busy}, 32'd0);
    end

    // LSB-first variant
    acc_l = 0;
    rx_l  = '0;
    u_if_l.rd_req  = 1'b1;
    u_if_l.rd_addr = 4'd1;
    push_l(bank[1]);
    tick();
    u_if_l.rd_req = 1'b0;
    n = 0;
    while (u_if_l.rd_busy && n < 100) begin
      tick();
      n++;
    end
    check("lsb_busy_cycles", n, DW + 1);
    check("lsb_beats", acc_l, DW);
    check("lsb_word", {24'd0, rx_l}, 32'h01);
    check("lsb_queue_empty", q_l.size(), 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/simple_reg_reader.md
Name: simple_reg_reader

Overview:
Read-back side of the serial configuration register path. Takes a read request for one register in the bank and fetches the parallel word over the bank read port. Shifts the word out serially on dout with a valid/ready handshake, one bit per accepted beat. Sits between the register bank and the chip's debug/scan readout, mirroring the serial we/din write path.

Parameters:
DATA_W, 8, register word width in bits (>=2)
ADDR_W, 4, register address width
MSB_FIRST, 1, 1 = shift out bit DATA_W-1 first; 0 = bit 0 first

Ports:
clk  input  1  system clock, all state on rising edge
reset_l  input  1  asynchronous active-low reset
rd_req  input  1  read request, sampled only in IDLE
rd_addr  input  ADDR_W  register address, captured with rd_req
rd_busy  output  1  high from the cycle after an accepted request until the last bit is accepted
rd_drop  output  1  one-cycle pulse: rd_req seen while not in IDLE (request discarded)
bank_addr  output  ADDR_W  registered address to the bank read port
bank_rdata  input  DATA_W  bank read data, combinational from bank_addr
dout  output  1  serial data bit
dout_valid  output  1  dout holds a valid bit
dout_last  output  1  qualifies the final bit of the word
dout_ready  input  1  downstream accepts the current bit

Behaviour:
- Reset (async, reset_l=0): state=IDLE. rd_busy, rd_drop, dout, dout_valid and dout_last=0. bank_addr=0, shift register=0, bit counter=0. Reset mid-word aborts the word. No partial bits after release.
- States: IDLE, FETCH, SHIFT.
- IDLE: rd_req=1 -> bank_addr<=rd_addr, go FETCH. rd_req=0 -> stay.
- FETCH (exactly 1 cycle): shreg<=bank_rdata, cnt<=DATA_W-1, go SHIFT. rd_busy=1.
- SHIFT: dout_valid=1. dout=shreg[DATA_W-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0). dout_last=(cnt==0).
  - dout_valid&dout_ready and cnt!=0: shift shreg by one toward the output end, zero-fill, cnt<=cnt-1.
  - dout_valid&dout_ready and cnt==0: go IDLE; dout_valid, dout_last and rd_busy drop next cycle.
  - dout_ready=0: dout, dout_last and shreg held stable. No bit lost or duplicated.
- dout_valid, dout and dout_last are registered (driven from state/shreg). No combinational path from dout_ready to any output.
- Latency: rd_req sampled at edge k -> rd_busy=1 and FETCH after k. First dout_valid after edge k+1. With dout_ready tied high, the word completes in DATA_W SHIFT cycles. rd_busy=0 after edge k+1+DATA_W.
- Back-to-back: rd_req high in the same cycle the last bit is accepted is not accepted (state is still SHIFT) and pulses rd_drop. It is accepted the following cycle in IDLE. Minimum request spacing is DATA_W+2 cycles.
- rd_drop: registered, 1 for one cycle per cycle in which rd_req=1 and state!=IDLE.
- bank_addr holds its value after the word completes until the next accepted request.
- cnt width: clog2(DATA_W). Never wraps below 0: the transition out at cnt==0 precedes any decrement.
- dout=0 whenever dout_valid=0.

Decomposition:
- Shared package simple_reg_pkg: state encoding (IDLE=2'd0, FETCH=2'd1, SHIFT=2'd2), default DATA_W/ADDR_W, clog2 function.
- One natural sub-module: simple_reg_piso (parallel-load shift register with load, shift_en, MSB_FIRST, dout, cnt/last). The FSM stays in the top.

Test Plan:
- Reset then idle: reset_l=0 for 11 ns, release, rd_req=0 for 10 cycles -> rd_busy, dout_valid and rd_drop stay 0. bank_addr=0.
- Single read, ready high: bank[3]=8'hA5, rd_req=1 addr=3 for one cycle -> bank_addr=3, dout sequence 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles, dout_last only on the 8th, rd_busy=0 after DATA_W+2 cycles.
- Backpressure: bank[5]=8'h3C, dout_ready toggled 1,0,0,1,... -> dout and dout_last stable across low cycles, received word 8'h3C, exactly 8 accepted beats.
- Request while busy: second rd_req (addr=7) during SHIFT of addr=3 -> rd_drop pulses once per asserted cycle, output still bank[3], bank_addr stays 3.
- Reset mid-operation: reset_l=0 after 3 accepted bits of 8'hFF -> dout_valid, rd_busy and dout fall immediately (async). After release, IDLE with no residual bits.
- LSB-first variant: MSB_FIRST=0, bank[1]=8'h01 -> first bit 1 then seven 0s, last asserted on the 8th bit.
